demux_reg: RTL and testbench
============================

// Module: demux_reg
// PURPOSE
//  Registered 1-to-2 steering stage: the inverse of the pipeline 2:1 select mux. One input word
//  plus sel is routed to exactly one of two destinations; each destination has a one-entry
//  output register with valid/ready handshake, so back-pressure on one path never corrupts the
//  other. Used where a pipeline result splits between two consumers (e.g. ALU vs. memory path).
// PARAMETERS
//  WIDTH    32  data word width in bits
//  CNT_W    16  width of per-output transfer counters
// PORTS
//  clk         in   1      single clock; all state updates on rising edge
//  rst_n       in   1      synchronous, active-low reset
//  flush       in   1      synchronous clear of both output slots (counters kept)
//  in_valid    in   1      input word present
//  in_ready    out  1      stage accepts input this cycle
//  sel         in   1      0 -> destination 1, 1 -> destination 2
//  data_in     in   WIDTH  input word
//  out1_valid  out  1      slot 1 holds a word
//  out1_ready  in   1      destination 1 consumes this cycle
//  data_out_1  out  WIDTH  slot 1 word
//  out2_valid  out  1      slot 2 holds a word
//  out2_ready  in   1      destination 2 consumes this cycle
//  data_out_2  out  WIDTH  slot 2 word
//  cnt_out1    out  CNT_W  words delivered on destination 1 (valid&&ready), wraps
//  cnt_out2    out  CNT_W  words delivered on destination 2, wraps
// BEHAVIOUR
//  - Reset (rst_n=0 at edge): out1_valid=out2_valid=0, data_out_1=data_out_2=0, cnt_out1=cnt_out2=0.
//    Reset dominates flush and any handshake in the same cycle; in-flight words are discarded.
//  - in_ready is combinational: sel ? (!out2_valid || out2_ready) : (!out1_valid || out1_ready).
//    sel and data_in must stay stable while in_valid=1 and in_ready=0; in_ready=0 while flush=1.
//  - Accept = in_valid && in_ready && !flush. On accept the selected slot loads data_in and sets
//    valid at the next edge: latency exactly 1 cycle, full throughput (1 word/cycle) per slot.
//  - Drain = outN_valid && outN_ready: slot N clears valid next edge unless refilled by an accept
//    in the same cycle (simultaneous drain+fill -> valid stays 1, new data loaded).
//  - Unselected slot is unaffected by the input side; its data/valid hold until drained.
//  - data_out_N holds last value after drain (not zeroed); only valid qualifies it.
//  - flush=1: both valid bits clear next edge; a drain occurring in that cycle still counts.
//  - cnt_outN increments by 1 on each drain of slot N; wraps 2^CNT_W-1 -> 0 with no flag.
//  - Full slot with ready low: slot holds data/valid indefinitely, in_ready=0 for that sel only.
//  - No state machine beyond the per-slot valid bit (EMPTY <-> FULL): EMPTY->FULL on accept,
//    FULL->EMPTY on drain without accept or on flush, FULL->FULL on drain+accept or stall.
// STRUCTURE
//  - Shared package: localparams SEL_OUT1=1'b0, SEL_OUT2=1'b1; default WIDTH=32 (datapath width).
//  - One sub-module: demux_slot #(WIDTH,CNT_W) — one-entry register slice with load, drain, flush,
//    counter and local ready; demux_reg instantiates it twice and forms in_ready/load from sel.
// TESTING
//  1 Reset: rst_n=0 two cycles with in_valid=1 -> both valid=0, data=0, counters=0, no capture.
//  2 Steer: sel=0,data_in=32'hDEAD_BEEF,out1_ready=1 -> next cycle out1_valid=1,data_out_1=DEADBEEF,
//    out2_valid stays 0; sel=1,32'h1234_5678 -> appears only on data_out_2.
//  3 Back-pressure: out1_ready=0, two sel=0 words -> first held in slot 1, in_ready=0 for sel=0,
//    in_ready=1 for sel=1 and a sel=1 word passes to slot 2 unblocked.
//  4 Full-rate: slot 1 full, out1_ready=1 and new sel=0 word each cycle for 8 cycles ->
//    out1_valid stays 1, words 1..8 delivered in order, cnt_out1=8.
//  5 Flush: both slots full, flush=1 with out2_ready=1 -> both valid=0 next cycle, cnt_out2+=1,
//    in_ready=0 during flush, input word not captured.
//  6 Wrap/reset mid-op: CNT_W=4, 17 drains on slot 2 -> cnt_out2=1; then rst_n=0 while slots full
//    -> all outputs return to reset values next edge.

Source files
------------

// File: rtl/demux_reg_pkg.sv
// Shared definitions for the registered 1-to-2 steering stage.
// Select encodings and default datapath/counter widths.
package demux_reg_pkg;

    localparam logic SEL_OUT1 = 1'b0;
    localparam logic SEL_OUT2 = 1'b1;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_CNT_W = 16;

endpackage

// File: rtl/demux_slot.sv
// One-entry output register slice with valid/ready handshake,
// synchronous flush and a wrapping delivered-word counter.
module demux_slot
    import demux_reg_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             ready_i,
    output logic             free_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic [CNT_W-1:0] cnt_o
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             drain;

    assign drain  = valid_q && ready_i;
    assign free_o = !valid_q || ready_i;

    // Flush wins over a same-cycle load; the caller already blocks loads then.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
        end else if (drain) begin
            valid_d = 1'b0;
        end
        if (load_i && !flush_i) begin
            data_d = data_i;
        end
        if (drain) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign cnt_o   = cnt_q;

endmodule

// File: rtl/demux_reg.sv
// Registered 1-to-2 steering stage: routes one input word to one
// of two independently back-pressured one-entry output slots.
module demux_reg
    import demux_reg_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             sel,
    input  logic [WIDTH-1:0] data_in,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] data_out_1,
    output logic             out2_valid,
    input  logic             out2_ready,
    output logic [WIDTH-1:0] data_out_2,
    output logic [CNT_W-1:0] cnt_out1,
    output logic [CNT_W-1:0] cnt_out2
);

    logic free1, free2;
    logic accept, load1, load2;

    assign in_ready = !flush && ((sel == SEL_OUT2) ? free2 : free1);
    assign accept   = in_valid && in_ready;
    assign load1    = accept && (sel == SEL_OUT1);
    assign load2    = accept && (sel == SEL_OUT2);

    demux_slot #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_slot1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (flush),
        .load_i  (load1),
        .data_i  (data_in),
        .ready_i (out1_ready),
        .free_o  (free1),
        .valid_o (out1_valid),
        .data_o  (data_out_1),
        .cnt_o   (cnt_out1)
    );

    demux_slot #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_slot2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (flush),
        .load_i  (load2),
        .data_i  (data_in),
        .ready_i (out2_ready),
        .free_o  (free2),
        .valid_o (out2_valid),
        .data_o  (data_out_2),
        .cnt_o   (cnt_out2)
    );

endmodule

// File: tb/tb_demux_reg.sv
// Directed bench for demux_reg: vector table plus hand-written
// sequences for full-rate streaming, counter wrap and mid-op reset.
module tb_demux_reg;

    localparam int W  = 32;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n, flush, in_valid, in_ready, sel;
    logic [W-1:0]  data_in, data_out_1, data_out_2;
    logic          out1_valid, out1_ready, out2_valid, out2_ready;
    logic [CW-1:0] cnt_out1, cnt_out2;

    int n_tests = 0;
    int n_fail  = 0;

    demux_reg #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .sel        (sel),
        .data_in    (data_in),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .data_out_1 (data_out_1),
        .out2_valid (out2_valid),
        .out2_ready (out2_ready),
        .data_out_2 (data_out_2),
        .cnt_out1   (cnt_out1),
        .cnt_out2   (cnt_out2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          rst_n, flush, iv, sel;
        logic [W-1:0]  din;
        logic          r1, r2;
        logic          chk_rdy, rdy;
        logic          v1;
        logic [W-1:0]  d1;
        logic          v2;
        logic [W-1:0]  d2;
        logic [CW-1:0] c1, c2;
    } vec_t;

    vec_t vt[11];

    task automatic check(input string name, input logic [W-1:0] act,
                         input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic f, input logic iv,
                         input logic s, input logic [W-1:0] d,
                         input logic r1, input logic r2);
        rst_n      = r;
        flush      = f;
        in_valid   = iv;
        sel        = s;
        data_in    = d;
        out1_ready = r1;
        out2_ready = r2;
    endtask

    initial begin
        // rst flush iv sel din r1 r2 | chk rdy | v1 d1 v2 d2 c1 c2
        vt[0]  = '{0,0,1,0,32'hAAAA_AAAA,1,1, 0,0, 0,32'h0,0,32'h0,0,0};
        vt[1]  = '{0,0,1,0,32'hAAAA_AAAA,1,1, 1,1, 0,32'h0,0,32'h0,0,0};
        vt[2]  = '{1,0,1,0,32'hDEAD_BEEF,1,1, 1,1,
                   1,32'hDEAD_BEEF,0,32'h0,0,0};
        vt[3]  = '{1,0,1,1,32'h1234_5678,0,1, 1,1,
                   1,32'hDEAD_BEEF,1,32'h1234_5678,0,0};
        vt[4]  = '{1,0,0,1,32'h0,1,1, 1,1,
                   0,32'hDEAD_BEEF,0,32'h1234_5678,1,1};
        vt[5]  = '{1,0,1,0,32'h1111_1111,0,0, 1,1,
                   1,32'h1111_1111,0,32'h1234_5678,1,1};
        vt[6]  = '{1,0,1,0,32'h2222_2222,0,0, 1,0,
                   1,32'h1111_1111,0,32'h1234_5678,1,1};
        vt[7]  = '{1,0,1,1,32'h3333_3333,0,0, 1,1,
                   1,32'h1111_1111,1,32'h3333_3333,1,1};
        vt[8]  = '{1,0,1,0,32'h2222_2222,1,0, 1,1,
                   1,32'h2222_2222,1,32'h3333_3333,2,1};
        vt[9]  = '{1,1,1,1,32'h4444_4444,0,1, 1,0,
                   0,32'h2222_2222,0,32'h3333_3333,2,2};
        vt[10] = '{1,0,0,0,32'h0,1,1, 1,1,
                   0,32'h2222_2222,0,32'h3333_3333,2,2};

        drive(0, 0, 0, 0, '0, 0, 0);

        foreach (vt[i]) begin
            @(negedge clk);
            drive(vt[i].rst_n, vt[i].flush, vt[i].iv, vt[i].sel,
                  vt[i].din, vt[i].r1, vt[i].r2);
            #1;
            if (vt[i].chk_rdy)
                check($sformatf("v%0d in_ready", i), W'(in_ready),
                      W'(vt[i].rdy));
            @(posedge clk);
            #1;
            check($sformatf("v%0d out1_valid", i), W'(out1_valid), W'(vt[i].v1));
            check($sformatf("v%0d data_out_1", i), data_out_1, vt[i].d1);
            check($sformatf("v%0d out2_valid", i), W'(out2_valid), W'(vt[i].v2));
            check($sformatf("v%0d data_out_2", i), data_out_2, vt[i].d2);
            check($sformatf("v%0d cnt_out1", i), W'(cnt_out1), W'(vt[i].c1));
            check($sformatf("v%0d cnt_out2", i), W'(cnt_out2), W'(vt[i].c2));
        end

        // Full-rate streaming into slot 1: cnt_out1 starts at 2.
        @(negedge clk);
        drive(1, 0, 1, 0, 32'h100, 1, 0);
        for (int k = 2; k <= 9; k++) begin
            @(negedge clk);
            check($sformatf("rate%0d out1_valid", k), W'(out1_valid), W'(1));
            check($sformatf("rate%0d data_out_1", k), data_out_1,
                  W'(32'h100 + k - 1 - 1));
            if (k <= 8) drive(1, 0, 1, 0, W'(32'h100 + k - 1), 1, 0);
            else        drive(1, 0, 0, 0, '0, 1, 0);
            #1;
            check($sformatf("rate%0d in_ready", k), W'(in_ready), W'(1));
        end
        @(negedge clk);
        check("rate out1_valid end", W'(out1_valid), W'(0));
        check("rate cnt_out1", W'(cnt_out1), W'(10));

        // Counter wrap on slot 2 from a fresh reset.
        drive(0, 0, 0, 0, '0, 0, 0);
        @(negedge clk);
        check("wrap rst cnt_out2", W'(cnt_out2), W'(0));
        for (int i = 0; i < 17; i++) begin
            drive(1, 0, 1, 1, W'(i), 0, 1);
            @(negedge clk);
        end
        check("wrap cnt_out2 16 drains", W'(cnt_out2), W'(0));
        check("wrap data_out_2 last", data_out_2, W'(16));
        drive(1, 0, 0, 1, '0, 0, 1);
        @(negedge clk);
        check("wrap cnt_out2 17 drains", W'(cnt_out2), W'(1));
        check("wrap out2_valid", W'(out2_valid), W'(0));

        // Fill both slots, then reset while full.
        drive(1, 0, 1, 0, 32'hA5A5_0001, 0, 0);
        @(negedge clk);
        drive(1, 0, 1, 1, 32'hA5A5_0002, 0, 0);
        @(negedge clk);
        check("full out1_valid", W'(out1_valid), W'(1));
        check("full out2_valid", W'(out2_valid), W'(1));
        check("full data_out_2", data_out_2, 32'hA5A5_0002);
        drive(0, 1, 1, 0, 32'hFFFF_FFFF, 1, 1);
        @(negedge clk);
        check("midrst out1_valid", W'(out1_valid), W'(0));
        check("midrst out2_valid", W'(out2_valid), W'(0));
        check("midrst data_out_1", data_out_1, W'(0));
        check("midrst data_out_2", data_out_2, W'(0));
        check("midrst cnt_out1", W'(cnt_out1), W'(0));
        check("midrst cnt_out2", W'(cnt_out2), W'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
